// File: rtl/video_pkg.sv
// Shared definitions for the video I/O register block.
// Holds the CPU port address map and the palette write FSM state type.
package video_pkg;

   localparam logic [7:0] PORT_CTL      = 8'h00;
   localparam logic [7:0] PORT_C        = 8'h01;
   localparam logic [7:0] PORT_B        = 8'h02;
   localparam logic [7:0] PORT_A        = 8'h03;
   localparam logic [7:0] PORT_PAL_BASE = 8'h0C;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      PULSE
   } pal_state_t;

endpackage

// File: rtl/video_ports_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk_pix - destination clock
//   reset   - asynchronous, active-high
//   din     - asynchronous level input
//   rise    - high for one clk_pix cycle after a synchronised 0->1 transition
module video_ports_edge_sync (
   input  logic clk_pix,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/video_ports.sv
// CPU-side I/O register block feeding the video display stage.
// Ports:
//   clk_pix, reset          - pixel clock, asynchronous active-high reset
//   io_addr/io_din/io_wr/io_rd/io_dout - CPU I/O cycle (clk_pix-synchronous strobes)
//   retrace, int_ack, int_req - frame interrupt from display retrace
//   scroll, border, mode512, ppi_c - PPI port A/B/C latches
//   pal_we, pal_data        - delayed, timed palette write strobe and its data
module video_ports
   import video_pkg::*;
#(
   parameter int unsigned PAL_DELAY  = 4,
   parameter int unsigned PAL_PULSE  = 8,
   parameter logic [7:0]  SCROLL_RST = 8'hFF
) (
   input  logic       clk_pix,
   input  logic       reset,
   input  logic [7:0] io_addr,
   input  logic [7:0] io_din,
   input  logic       io_wr,
   input  logic       io_rd,
   output logic [7:0] io_dout,
   input  logic       retrace,
   input  logic       int_ack,
   output logic       int_req,
   output logic [7:0] scroll,
   output logic [3:0] border,
   output logic       mode512,
   output logic [7:0] ppi_c,
   output logic       pal_we,
   output logic [7:0] pal_data
);

   localparam logic [3:0] DELAY_LOAD = 4'(PAL_DELAY - 1);
   localparam logic [3:0] PULSE_LOAD = 4'(PAL_PULSE - 1);

   logic [7:0] port_b_q;

   assign border  = port_b_q[3:0];
   assign mode512 = port_b_q[4];

   // PPI register writes and registered reads. A read in the same cycle as a
   // write samples the registers before the write lands.
   always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
         scroll   <= SCROLL_RST;
         port_b_q <= 8'h00;
         ppi_c    <= 8'h00;
         io_dout  <= 8'h00;
      end else begin
         if (io_wr) begin
            case (io_addr)
               PORT_A: scroll   <= io_din;
               PORT_B: port_b_q <= io_din;
               PORT_C: ppi_c    <= io_din;
               PORT_CTL: begin
                  if (io_din[7]) begin
                     scroll   <= 8'h00;
                     port_b_q <= 8'h00;
                     ppi_c    <= 8'h00;
                  end else begin
                     ppi_c[io_din[3:1]] <= io_din[0];
                  end
               end
               default: ;
            endcase
         end
         if (io_rd) begin
            case (io_addr)
               PORT_A:  io_dout <= scroll;
               PORT_B:  io_dout <= port_b_q;
               PORT_C:  io_dout <= ppi_c;
               default: io_dout <= 8'hFF;
            endcase
         end
      end
   end

   // Palette write sequencer
   pal_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       pal_we_q, pal_we_d;
   logic [7:0] pal_data_q, pal_data_d;
   logic       pal_wr;

   assign pal_wr   = io_wr && (io_addr[7:2] == PORT_PAL_BASE[7:2]);
   assign pal_we   = pal_we_q;
   assign pal_data = pal_data_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pal_we_d   = pal_we_q;
      pal_data_d = pal_data_q;
      unique case (state_q)
         IDLE: begin
            if (pal_wr) begin
               pal_data_d = io_din;
               cnt_d      = DELAY_LOAD;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (pal_wr) begin
               pal_data_d = io_din;
               cnt_d      = DELAY_LOAD;
            end else if (cnt_q == 4'd0) begin
               pal_we_d = 1'b1;
               cnt_d    = PULSE_LOAD;
               state_d  = PULSE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         PULSE: begin
            if (pal_wr) begin
               // Drop the strobe for one cycle, then re-pulse with the new data.
               pal_we_d   = 1'b0;
               pal_data_d = io_din;
               cnt_d      = 4'd0;
               state_d    = WAIT;
            end else if (cnt_q == 4'd0) begin
               pal_we_d = 1'b0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         pal_we_q   <= 1'b0;
         pal_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pal_we_q   <= pal_we_d;
         pal_data_q <= pal_data_d;
      end
   end

   // Frame interrupt
   logic retrace_rise;

   video_ports_edge_sync u_retrace_sync (
      .clk_pix (clk_pix),
      .reset   (reset),
      .din     (retrace),
      .rise    (retrace_rise)
   );

   always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
         int_req <= 1'b0;
      end else if (retrace_rise) begin
         int_req <= 1'b1;
      end else if (int_ack) begin
         int_req <= 1'b0;
      end
   end

endmodule

// File: tb/tb_video_ports.sv
module tb_video_ports;

   logic       clk_pix = 1'b0;
   logic       reset   = 1'b1;
   logic [7:0] io_addr = 8'h00;
   logic [7:0] io_din  = 8'h00;
   logic       io_wr   = 1'b0;
   logic       io_rd   = 1'b0;
   logic [7:0] io_dout;
   logic       retrace = 1'b0;
   logic       int_ack = 1'b0;
   logic       int_req;
   logic [7:0] scroll;
   logic [3:0] border;
   logic       mode512;
   logic [7:0] ppi_c;
   logic       pal_we;
   logic [7:0] pal_data;

   int checks = 0;
   int errors = 0;

   // Scoreboard of expected read data, pushed when io_rd is driven.
   logic [7:0] rd_q[$];

   video_ports dut (
      .clk_pix  (clk_pix),
      .reset    (reset),
      .io_addr  (io_addr),
      .io_din   (io_din),
      .io_wr    (io_wr),
      .io_rd    (io_rd),
      .io_dout  (io_dout),
      .retrace  (retrace),
      .int_ack  (int_ack),
      .int_req  (int_req),
      .scroll   (scroll),
      .border   (border),
      .mode512  (mode512),
      .ppi_c    (ppi_c),
      .pal_we   (pal_we),
      .pal_data (pal_data)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic io_write(input logic [7:0] a, input logic [7:0] d);
      io_addr = a;
      io_din  = d;
      io_wr   = 1'b1;
      tick();
      io_wr   = 1'b0;
   endtask

   task automatic io_read(input logic [7:0] a, input logic [7:0] exp, input string name);
      logic [7:0] e;
      io_addr = a;
      io_rd   = 1'b1;
      rd_q.push_back(exp);
      tick();
      io_rd = 1'b0;
      e = rd_q.pop_front();
      checks++;
      if (io_dout !== e) begin
         errors++;
         $display("FAIL %s: io_dout=%h expected %h", name, io_dout, e);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if ({scroll, border, mode512, ppi_c} !== {8'hFF, 4'h0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_regs: scroll=%h border=%h mode512=%b ppi_c=%h expected ff 0 0 00",
                  scroll, border, mode512, ppi_c);
      end
      checks++;
      if ({pal_we, pal_data, int_req, io_dout} !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_out: pal_we=%b pal_data=%h int_req=%b io_dout=%h expected 0 00 0 00",
                  pal_we, pal_data, int_req, io_dout);
      end
      io_read(8'h03, 8'hFF, "reset_rd_scroll");
      io_read(8'h01, 8'h00, "reset_rd_ppic");
   endtask

   task automatic test_regs();
      io_write(8'h02, 8'h1A);
      checks++;
      if ({border, mode512} !== {4'hA, 1'b1}) begin
         errors++;
         $display("FAIL portb_wr: border=%h mode512=%b expected a 1", border, mode512);
      end
      io_read(8'h02, 8'h1A, "portb_rd");
      io_write(8'h00, 8'h07);
      checks++;
      if (ppi_c !== 8'h08) begin
         errors++;
         $display("FAIL bsr_set3: ppi_c=%h expected 08", ppi_c);
      end
      io_write(8'h00, 8'h0F);
      io_write(8'h03, 8'h42);
      io_read(8'h01, 8'h88, "bsr_set7_rd");
      tick();
      tick();
      checks++;
      if (io_dout !== 8'h88) begin
         errors++;
         $display("FAIL dout_hold: io_dout=%h expected 88", io_dout);
      end
      io_read(8'h10, 8'hFF, "unmapped_rd");
      // Simultaneous write and read of port A returns the old value.
      io_addr = 8'h03;
      io_din  = 8'h99;
      io_wr   = 1'b1;
      io_rd   = 1'b1;
      rd_q.push_back(8'h42);
      tick();
      io_wr = 1'b0;
      io_rd = 1'b0;
      begin
         logic [7:0] e;
         e = rd_q.pop_front();
         checks++;
         if (io_dout !== e || scroll !== 8'h99) begin
            errors++;
            $display("FAIL wr_rd_same: io_dout=%h scroll=%h expected %h 99", io_dout, scroll, e);
         end
      end
      io_write(8'h00, 8'h80);
      checks++;
      if ({scroll, ppi_c, border, mode512} !== {8'h00, 8'h00, 4'h0, 1'b0}) begin
         errors++;
         $display("FAIL mode_set: scroll=%h ppi_c=%h border=%h mode512=%b expected all 0",
                  scroll, ppi_c, border, mode512);
      end
      io_read(8'h02, 8'h00, "mode_set_rd_b");
   endtask

   // After the capturing edge, walk n edges expecting pal_we high on edges lo..hi.
   task automatic pal_trace(input int n, input int lo, input int hi, input logic [7:0] d,
                            input string name);
      logic we_e;
      int   bad;
      bad = 0;
      for (int i = 1; i <= n; i++) begin
         tick();
         we_e = (i >= lo) && (i <= hi);
         if (pal_we !== we_e || (we_e && pal_data !== d)) begin
            if (bad == 0)
               $display("FAIL %s: edge %0d pal_we=%b pal_data=%h expected %b %h",
                        name, i, pal_we, pal_data, we_e, d);
            bad++;
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   task automatic test_palette();
      io_write(8'h0C, 8'h5C);
      pal_trace(14, 4, 11, 8'h5C, "pal_basic");
   endtask

   task automatic test_pal_restart();
      io_write(8'h0C, 8'h11);
      tick();
      io_write(8'h0D, 8'h22);
      pal_trace(14, 4, 11, 8'h22, "pal_restart");
   endtask

   task automatic test_pal_pulse_rewrite();
      io_write(8'h0C, 8'h11);
      pal_trace(6, 4, 6, 8'h11, "pal_first");
      io_write(8'h0C, 8'h22);
      checks++;
      if (pal_we !== 1'b0 || pal_data !== 8'h22) begin
         errors++;
         $display("FAIL pal_gap: pal_we=%b pal_data=%h expected 0 22", pal_we, pal_data);
      end
      pal_trace(11, 1, 8, 8'h22, "pal_second");
   endtask

   task automatic test_interrupt();
      logic [2:0] seen;
      retrace = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen[i] = int_req;
      end
      checks++;
      if (seen !== 3'b100) begin
         errors++;
         $display("FAIL int_latency: int_req over 3 edges=%b expected 100", seen);
      end
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL int_ack: int_req=%b expected 0", int_req);
      end
      retrace = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (int_req !== 1'b0) begin
         errors++;
         $display("FAIL int_fall: int_req=%b expected 0", int_req);
      end
      retrace = 1'b1;
      tick();
      tick();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      checks++;
      if (int_req !== 1'b1) begin
         errors++;
         $display("FAIL int_set_wins: int_req=%b expected 1", int_req);
      end
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      retrace = 1'b0;
   endtask

   task automatic test_reset_mid();
      io_write(8'h03, 8'h33);
      io_write(8'h0C, 8'h77);
      pal_trace(5, 4, 5, 8'h77, "rst_pre");
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (pal_we !== 1'b0 || pal_data !== 8'h00 || scroll !== 8'hFF) begin
         errors++;
         $display("FAIL rst_async: pal_we=%b pal_data=%h scroll=%h expected 0 00 ff",
                  pal_we, pal_data, scroll);
      end
      tick();
      reset = 1'b0;
      pal_trace(16, 99, 99, 8'h00, "rst_no_resume");
   endtask

   initial begin
      test_reset();
      test_regs();
      test_palette();
      test_pal_restart();
      test_pal_pulse_rewrite();
      test_interrupt();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
